fifo_mem_ctrl: RTL and testbench

FIFO_MEM_CTRL -- requirements
Module: fifo_mem_ctrl

---
 rtl/fifo_mem_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_mem_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_ctrl.sv
// Synchronous single-clock FIFO with registered read port, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module fifo_mem_ctrl #(
  parameter int DATA_SIZE       = 6,
  parameter int MAIN_QUEUE_SIZE = 3,
  parameter int AF_TH           = 6,
  parameter int AE_TH           = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_SIZE-1:0]       data_in,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int DEPTH = 2 ** MAIN_QUEUE_SIZE;
  localparam int CW    = MAIN_QUEUE_SIZE + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [DATA_SIZE-1:0]       mem [DEPTH];
  logic [MAIN_QUEUE_SIZE-1:0] wr_ptr_reg;
  logic [MAIN_QUEUE_SIZE-1:0] rd_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [CW-1:0]              count_next;
  logic [DATA_SIZE-1:0]       data_out_reg;
  logic                       valid_reg;
  logic                       overflow_reg;
  logic                       underflow_reg;

  logic full_int;
  logic empty_int;
  logic push_ok;
  logic pop_ok;

  assign full_int  = (count_reg == DEPTH_C);
  assign empty_int = (count_reg == '0);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop from an empty FIFO never bypasses the push.
  assign push_ok = push && (!full_int || pop);
  assign pop_ok  = pop && !empty_int;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is never cleared; only the pointers and count define its content.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= pop_ok;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      // Reading the old word here means a full push+pop sees the head
      // before the same slot is overwritten.
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        data_out_reg <= mem[rd_ptr_reg];
      end
      if (push && full_int && !pop) begin
        overflow_reg <= 1'b1;
      end
      if (pop && empty_int) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign data_out      = data_out_reg;
  assign valid_out     = valid_reg;
  assign count         = count_reg;
  assign full          = full_int;
  assign empty         = empty_int;
  assign almost_full   = (count_reg >= AF_C);
  assign almost_empty  = (count_reg <= AE_C);
  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed plus randomized bench for fifo_mem_ctrl, checked every cycle
// against a queue-based reference model.
module tb_fifo_mem_ctrl;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow_err;
  logic          underflow_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference model state
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;
  bit            m_valid;
  bit            m_ovf;
  bit            m_udf;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(
    .DATA_SIZE(DW), .MAIN_QUEUE_SIZE(AW), .AF_TH(AF), .AE_TH(AE)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic model_update(input bit p, input bit q, input logic [DW-1:0] d, input bit r);
    int  n;
    bit  pop_acc;
    bit  push_acc;
    n = mq.size();
    if (r) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 0;
      m_ovf   = 0;
      m_udf   = 0;
    end else begin
      pop_acc  = q && (n > 0);
      push_acc = p && ((n < DEPTH) || q);
      if (q && n == 0) m_udf = 1;
      if (p && n == DEPTH && !q) m_ovf = 1;
      if (pop_acc) begin
        m_dout  = mq.pop_front();
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (push_acc) mq.push_back(d);
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("underflow_err", 32'(underflow_err), 32'(m_udf));
  endtask

  task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit r);
    reset   = r;
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    model_update(p, q, d, r);
    #1;
    n_step++;
    $display("step %0d rst=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h vld=%0b ovf=%0b udf=%0b",
             n_step, r, p, q, d, count, data_out, valid_out, overflow_err, underflow_err);
    compare_all();
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    mq.delete(); m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;

    // Reset state
    step(0, 0, 6'h00, 1);
    step(0, 0, 6'h00, 1);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, DW'(i), 0);
      if (i == 5) check("af_before_6th", 32'(almost_full), 32'd0);
      if (i == 6) check("af_after_6th", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full), 32'd1);

    // Overflow attempt
    step(1, 0, 6'h3F, 0);
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 6'h00, 0);
      check("drain_word", 32'(data_out), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow_err), 32'd1);

    // Underflow and empty push+pop
    step(0, 1, 6'h00, 0);
    check("udf_set", 32'(underflow_err), 32'd1);
    check("udf_data_hold", 32'(data_out), 32'h08);
    step(1, 1, 6'h2A, 0);
    check("empty_pp_count", 32'(count), 32'd1);
    check("empty_pp_valid", 32'(valid_out), 32'd0);
    step(0, 1, 6'h00, 0);
    check("empty_pp_word", 32'(data_out), 32'h2A);

    // Full simultaneous push+pop
    step(0, 0, 6'h00, 1);
    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0);
    step(1, 1, 6'h09, 0);
    check("full_pp_word", 32'(data_out), 32'h01);
    check("full_pp_count", 32'(count), 32'd8);
    check("full_pp_noerr", 32'(overflow_err), 32'd0);
    for (int i = 2; i <= 9; i++) begin
      step(0, 1, 6'h00, 0);
      check("full_pp_drain", 32'(data_out), 32'(i));
    end

    // Wrap-around with count held at 3
    for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 0);
    for (int i = 0; i < 20; i++) step(1, 1, DW'($urandom), 0);
    check("wrap_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 1, 6'h00, 0);

    // Reset mid-operation with push+pop
    step(0, 1, 6'h00, 0);
    for (int i = 0; i < 5; i++) step(1, 0, DW'(6'h10 + i), 0);
    step(1, 1, 6'h3C, 1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_udf", 32'(underflow_err), 32'd0);
    step(1, 0, 6'h21, 0);
    step(0, 1, 6'h00, 0);
    check("midrst_first_pop", 32'(data_out), 32'h21);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
           DW'($urandom), bit'($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
